// File: rtl/cpu_pkg.sv
// Shared CPU constants and types used by the register file and its HI/LO sub-block.
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;
  localparam reg_addr_t REG_V0   = 5'd2;
  localparam reg_addr_t REG_RA   = 5'd31;

endpackage

// File: rtl/reg_file_if.sv
// Register-file bus: two read ports, one GPR write port, HI/LO access and the $v0 debug tap.
interface reg_file_if
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W
);

  logic [ADDR_W-1:0] read_addr_a;
  logic [ADDR_W-1:0] read_addr_b;
  logic [DATA_W-1:0] read_data_a;
  logic [DATA_W-1:0] read_data_b;
  logic              write_enable;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] write_data;
  logic              hi_write_enable;
  logic              lo_write_enable;
  logic [DATA_W-1:0] hi_data_in;
  logic [DATA_W-1:0] lo_data_in;
  logic [DATA_W-1:0] hi_data_out;
  logic [DATA_W-1:0] lo_data_out;
  logic [DATA_W-1:0] register_v0;

  modport master (
    output read_addr_a, read_addr_b,
    output write_enable, write_addr, write_data,
    output hi_write_enable, lo_write_enable, hi_data_in, lo_data_in,
    input  read_data_a, read_data_b, hi_data_out, lo_data_out, register_v0
  );

  modport slave (
    input  read_addr_a, read_addr_b,
    input  write_enable, write_addr, write_data,
    input  hi_write_enable, lo_write_enable, hi_data_in, lo_data_in,
    output read_data_a, read_data_b, hi_data_out, lo_data_out, register_v0
  );

endinterface

// File: rtl/reg_file_hilo_reg.sv
// HI/LO multiply/divide result registers with independent enables.
// Optional macro REG_FILE_WRITE_BYPASS_EN forwards incoming HI/LO values to the outputs.
module hilo_reg
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hi_write_enable,
  input  logic              lo_write_enable,
  input  logic [DATA_W-1:0] hi_data_in,
  input  logic [DATA_W-1:0] lo_data_in,
  output logic [DATA_W-1:0] hi_data_out,
  output logic [DATA_W-1:0] lo_data_out
);

  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (hi_write_enable) hi_q <= hi_data_in;
      if (lo_write_enable) lo_q <= lo_data_in;
    end
  end

`ifdef REG_FILE_WRITE_BYPASS_EN
  // Forwarded values must still be masked while reset is held.
  always_comb begin
    hi_data_out = hi_q;
    lo_data_out = lo_q;
    if (reset) begin
      hi_data_out = '0;
      lo_data_out = '0;
    end else begin
      if (hi_write_enable) hi_data_out = hi_data_in;
      if (lo_write_enable) lo_data_out = lo_data_in;
    end
  end
`else
  assign hi_data_out = hi_q;
  assign lo_data_out = lo_q;
`endif

endmodule

// File: rtl/reg_file.sv
// MIPS 32x32 GPR file with two combinational reads, one synchronous write and HI/LO.
// Optional macro REG_FILE_WRITE_BYPASS_EN enables same-cycle write-through forwarding.
module reg_file
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic       clk,
  input  logic       reset,
  reg_file_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);
  localparam logic [ADDR_W-1:0] V0_IDX   = ADDR_W'(REG_V0);

  logic [DATA_W-1:0] regs [DEPTH];
  logic              gpr_we;

  // $0 is never stored, so the array slot stays at its reset value of zero.
  assign gpr_we = bus.write_enable && (bus.write_addr != ZERO_IDX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (gpr_we) begin
      regs[bus.write_addr] <= bus.write_data;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              rst_now,
    input logic              we_now,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata
  );
    logic [DATA_W-1:0] val;
    val = stored;
    if (rst_now || addr == ZERO_IDX) begin
      val = '0;
    end else begin
`ifdef REG_FILE_WRITE_BYPASS_EN
      if (we_now && waddr == addr) val = wdata;
`else
      if (we_now && waddr == addr && 1'b0) val = wdata;
`endif
    end
    return val;
  endfunction

  always_comb begin
    bus.read_data_a = read_port(bus.read_addr_a, regs[bus.read_addr_a], reset,
                                bus.write_enable, bus.write_addr, bus.write_data);
    bus.read_data_b = read_port(bus.read_addr_b, regs[bus.read_addr_b], reset,
                                bus.write_enable, bus.write_addr, bus.write_data);
  end

  assign bus.register_v0 = regs[V0_IDX];

  hilo_reg #(
    .DATA_W (DATA_W)
  ) u_hilo (
    .clk             (clk),
    .reset           (reset),
    .hi_write_enable (bus.hi_write_enable),
    .lo_write_enable (bus.lo_write_enable),
    .hi_data_in      (bus.hi_data_in),
    .lo_data_in      (bus.lo_data_in),
    .hi_data_out     (bus.hi_data_out),
    .lo_data_out     (bus.lo_data_out)
  );

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- 32x32 MIPS general-purpose register file with two combinational read ports and one synchronous write port, plus HI/LO multiply/divide registers.
- Consumes the write address produced by the decode stage's write-address select (rt, rd, or 31 for link), together with writeback data.
- Feeds rs/rt operands to the ALU and exposes $v0 for the testbench.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; depth is 2**ADDR_W

Ports:
- clk  in  1  system clock, rising-edge active
- reset  in  1  asynchronous, active-high reset
- read_addr_a  in  ADDR_W  rs index
- read_addr_b  in  ADDR_W  rt index
- read_data_a  out  DATA_W  contents of register read_addr_a
- read_data_b  out  DATA_W  contents of register read_addr_b
- write_enable  in  1  GPR write strobe
- write_addr  in  ADDR_W  GPR destination (rt/rd/31 from decode select)
- write_data  in  DATA_W  writeback value
- hi_write_enable  in  1  HI write strobe
- lo_write_enable  in  1  LO write strobe
- hi_data_in  in  DATA_W  new HI value
- lo_data_in  in  DATA_W  new LO value
- hi_data_out  out  DATA_W  current HI
- lo_data_out  out  DATA_W  current LO
- register_v0  out  DATA_W  current $2, for debug and test

Behaviour:
- Clock and reset: one clock domain, clk. Reset is asynchronous and active-high on port reset. Asserting reset at any time immediately clears all 32 GPRs, HI and LO to 0. All outputs then read 0 combinationally, with no clock edge needed.
- Write during reset: a write presented in the same cycle that reset is high is discarded. Reset dominates.
- GPR write: on the rising clk edge with write_enable=1 and reset=0, reg[write_addr] <= write_data. The new value is visible on the read ports after that edge, so write latency is 1 cycle.
- Register $0: writes to address 0 are ignored. Reads of address 0 always return 0, regardless of write_enable or bypass.
- Reads: read_data_a/b are purely combinational from the array, with zero latency. Both ports may address the same register and both return the same value.
- HI/LO: HI and LO are independent registers with their own enables. Both may be written on the same edge, and they may be written on the same edge as a GPR write.
- register_v0: always equals the stored reg[2]. It is never bypassed.
- Simultaneous read/write to the same nonzero address without the bypass feature: the read port returns the OLD value until the edge.
- X handling: write_addr and write_data are don't-care when write_enable=0, and no state changes.
- No handshake and no stall: every enabled edge commits.

Optional Feature:
- Macro: REG_FILE_WRITE_BYPASS_EN.
- Defined: if write_enable=1, write_addr!=0, and write_addr==read_addr_x, then read_data_x = write_data in the same cycle (write-through forwarding). The same rule applies to HI/LO: when hi_write_enable=1, hi_data_out = hi_data_in, and when lo_write_enable=1, lo_data_out = lo_data_in.
- Reset still forces all outputs to 0 while asserted.
- Undefined: no forwarding; outputs reflect stored state only.

Decomposition:
- Shared package (cpu_pkg):
  - DATA_W/ADDR_W constants
  - named register indices REG_ZERO=0, REG_V0=2, REG_RA=31
  - typedef word_t [31:0]
  - typedef reg_addr_t [4:0]
- One sub-module is natural: hilo_reg, holding HI and LO with their enables, async reset and optional bypass. The GPR array stays in reg_file.

Test Plan:
- Reset: assert reset mid-run after writing reg5=0xDEADBEEF and HI=0x1234 -> read_data_a(addr 5)=0, hi_data_out=0 immediately, with no clock edge.
- Zero register: write_enable=1, write_addr=0, write_data=0xFFFFFFFF, edge -> read of addr 0 returns 0. With the bypass macro defined, it also returns 0 in the same cycle.
- Link write: write addr 31 with 0xBFC00008, edge -> read_data_b(addr 31)=0xBFC00008. Write addr 2 with 7 -> register_v0=7 after the edge.
- Dual read: after writing reg8=0x11 and reg9=0x22, read a=8, b=9 -> 0x11/0x22. Read a=b=9 -> both 0x22.
- Same-cycle read/write on reg4 (old value 1, new value 2):
  - without the bypass macro, the read returns 1 before the edge and 2 after;
  - with the bypass macro, the read returns 2 before the edge.
- HI/LO: hi_write_enable=1 only with hi_data_in=0xA, lo_data_in=0xB -> HI=0xA, LO unchanged (0). Then both enables set with 3/4 -> HI=3, LO=4.
